// File: rtl/main_pkg.sv
// main_pkg -- definitions shared by the sorter (main) and its storage (main_mem).
//   WORD_W / ARR_LEN / IDX_W : word width, number of words per array, word index width
//   DONE_LATENCY             : rising edges from the start edge until done_port is high
//   state_t                  : sorter FSM states
//   init_a_word()            : power-up/reset contents of data array A
package main_pkg;

  localparam int WORD_W       = 32;
  localparam int ARR_LEN      = 8;
  localparam int IDX_W        = 3;
  localparam int DONE_LATENCY = 62;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_COPY,
    ST_DONE
  } state_t;

  function automatic logic [WORD_W-1:0] init_a_word(input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] v;
    case (idx)
      3'd0:    v = 32'h0000_0007;  //    7
      3'd1:    v = 32'hFFFF_FFFD;  //   -3
      3'd2:    v = 32'h0000_0021;  //   33
      3'd3:    v = 32'h0000_0000;  //    0
      3'd4:    v = 32'h0000_000C;  //   12
      3'd5:    v = 32'hFFFF_FF80;  // -128
      3'd6:    v = 32'h0000_0005;  //    5
      default: v = 32'h0000_0001;  //    1
    endcase
    return v;
  endfunction

endpackage

// File: rtl/main_mem.sv
// main_mem -- byte-addressed storage for data array A and scratch buffer B.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset (restores A/B contents)
//   i_slave_en          : slave ports may read/write the arrays (sorter idle)
//   i_eng_raddr/rdata   : engine word read, combinational; addr[3] selects B, [2:0] word
//   i_eng_we/waddr/wdata: engine word write, same addressing
//   i_oe/i_we/i_addr/i_wdata/i_size : two byte-wide slave channels (ch0 in low slices)
//   o_rdata/o_rdy       : registered slave read data and acknowledge per channel
module main_mem
  import main_pkg::*;
#(
  parameter int A_BASE  = 64,
  parameter int B_BASE  = 32,
  parameter int B_ALIAS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_slave_en,
  input  logic [3:0]        i_eng_raddr,
  output logic [WORD_W-1:0] o_eng_rdata,
  input  logic              i_eng_we,
  input  logic [3:0]        i_eng_waddr,
  input  logic [WORD_W-1:0] i_eng_wdata,
  input  logic [1:0]        i_oe,
  input  logic [1:0]        i_we,
  input  logic [13:0]       i_addr,
  input  logic [15:0]       i_wdata,
  input  logic [7:0]        i_size,
  output logic [15:0]       o_rdata,
  output logic [1:0]        o_rdy
);

  localparam logic [7:0] SPAN = 8'(ARR_LEN * 4);

  logic [WORD_W-1:0] r_a [ARR_LEN];
  logic [WORD_W-1:0] r_b [ARR_LEN];

  logic [1:0]      w_hit_a;
  logic [1:0]      w_hit_b;
  logic [1:0][2:0] w_word;
  logic [1:0][1:0] w_lane;

  assign o_eng_rdata = i_eng_raddr[3] ? r_b[i_eng_raddr[2:0]] : r_a[i_eng_raddr[2:0]];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [7:0] w_ad;
      logic [7:0] w_off_a;
      logic [7:0] w_off_b;
      logic [7:0] w_off_al;
      logic [4:0] w_off;
      logic       w_in_a;
      logic       w_in_b;
      logic       w_in_al;
      logic       w_legal;
      logic [7:0] w_byte;
      logic [7:0] r_rdata;
      logic       r_rdy;

      assign w_ad     = {1'b0, i_addr[gi*7 +: 7]};
      assign w_off_a  = w_ad - 8'(A_BASE);
      assign w_off_b  = w_ad - 8'(B_BASE);
      assign w_off_al = w_ad - 8'(B_ALIAS);
      assign w_in_a   = (w_ad >= 8'(A_BASE))  && (w_off_a  < SPAN);
      assign w_in_b   = (w_ad >= 8'(B_BASE))  && (w_off_b  < SPAN);
      assign w_in_al  = (w_ad >= 8'(B_ALIAS)) && (w_off_al < SPAN);
      assign w_off    = w_in_a ? w_off_a[4:0] : (w_in_b ? w_off_b[4:0] : w_off_al[4:0]);

      // Only byte-sized accesses while the sorter is idle touch the arrays.
      assign w_legal      = i_slave_en && (i_size[gi*4 +: 4] == 4'd8);
      assign w_hit_a[gi]  = w_legal && w_in_a;
      assign w_hit_b[gi]  = w_legal && !w_in_a && (w_in_b || w_in_al);
      assign w_word[gi]   = w_off[4:2];
      assign w_lane[gi]   = w_off[1:0];

      always_comb begin
        w_byte = 8'd0;
        if (w_hit_a[gi]) begin
          w_byte = r_a[w_word[gi]][{w_lane[gi], 3'b000} +: 8];
        end else if (w_hit_b[gi]) begin
          w_byte = r_b[w_word[gi]][{w_lane[gi], 3'b000} +: 8];
        end
      end

      // Every request is acknowledged; data is zero unless it was a serviced read.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rdata <= 8'd0;
          r_rdy   <= 1'b0;
        end else begin
          r_rdy   <= i_oe[gi] | i_we[gi];
          r_rdata <= i_oe[gi] ? w_byte : 8'd0;
        end
      end

      assign o_rdata[gi*8 +: 8] = r_rdata;
      assign o_rdy[gi]          = r_rdy;
    end
  endgenerate

  // Channel 1 is applied after channel 0 so it wins a same-byte collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < ARR_LEN; k++) begin
        r_a[k] <= init_a_word(3'(k));
        r_b[k] <= '0;
      end
    end else begin
      if (i_eng_we) begin
        if (i_eng_waddr[3]) begin
          r_b[i_eng_waddr[2:0]] <= i_eng_wdata;
        end else begin
          r_a[i_eng_waddr[2:0]] <= i_eng_wdata;
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (i_we[c] && w_hit_a[c]) begin
          r_a[w_word[c]][{w_lane[c], 3'b000} +: 8] <= i_wdata[c*8 +: 8];
        end
        if (i_we[c] && w_hit_b[c]) begin
          r_b[w_word[c]][{w_lane[c], 3'b000} +: 8] <= i_wdata[c*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/main.sv
// main -- bottom-up merge sort (run widths 1, 2, 4) of the 8 signed words in A,
// merging A -> B each pass and copying B back to A.
//   clock, reset (async, active low), start_port : control
//   S_*  : two byte-wide slave channels into A/B, serviced only while idle
//   done_port      : one-cycle pulse, high 62 rising edges after the edge that
//                    samples start_port (fixed, data independent)
//   Sout_Rdata_ram / Sout_DataRdy : slave read data / acknowledge
// Per pair of runs: 2 LOAD cycles fetch both heads, then one MERGE cycle per
// output word (one read refills the consumed head, one write into B).
// COPY moves one word per cycle. Totals: 24 + 20 + 18 = 62 cycles.
module main
  import main_pkg::*;
#(
  parameter int MEM_var_28859_28863 = 64,
  parameter int MEM_var_28861_28867 = 32,
  parameter int MEM_var_29007_28863 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy
);

  state_t r_state;
  state_t w_state_next;

  logic [3:0]               r_width;      // current run width: 1, 2, 4
  logic [2:0]               r_base;       // first word of the current pair of runs
  logic [3:0]               r_i;          // words consumed from the left run
  logic [3:0]               r_j;          // words consumed from the right run
  logic                     r_load_step;
  logic [2:0]               r_copy;
  logic signed [WORD_W-1:0] r_left;
  logic signed [WORD_W-1:0] r_right;

  logic [3:0]        w_two_w;
  logic              w_take_left;
  logic              w_pair_last;
  logic              w_last_pair;
  logic              w_copy_last;
  logic              w_last_pass;
  logic [2:0]        w_load_idx;
  logic [2:0]        w_refill_idx;
  logic [2:0]        w_out_idx;
  logic [3:0]        w_eng_raddr;
  logic [WORD_W-1:0] w_eng_rdata;
  logic              w_eng_we;
  logic [3:0]        w_eng_waddr;
  logic [WORD_W-1:0] w_eng_wdata;

  assign w_two_w     = {r_width[2:0], 1'b0};
  // Left wins ties (stability); an exhausted run never wins.
  assign w_take_left = (r_j == r_width) || ((r_i != r_width) && (r_left <= r_right));
  assign w_pair_last = (r_i + r_j + 4'd1) == w_two_w;
  assign w_last_pair = ({1'b0, r_base} + w_two_w) == 4'd8;
  assign w_copy_last = (r_copy == 3'd7);
  assign w_last_pass = (r_width == 4'd4);

  assign w_load_idx   = 3'({1'b0, r_base} + (r_load_step ? r_width : 4'd0));
  // Past the end of a run this fetches an unused word; the head is then ignored.
  assign w_refill_idx = w_take_left ? 3'({1'b0, r_base} + r_i + 4'd1)
                                    : 3'({1'b0, r_base} + r_width + r_j + 4'd1);
  assign w_out_idx    = 3'({1'b0, r_base} + r_i + r_j);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_port)  w_state_next = ST_LOAD;
      ST_LOAD:  if (r_load_step) w_state_next = ST_MERGE;
      ST_MERGE: if (w_pair_last) w_state_next = w_last_pair ? ST_COPY : ST_LOAD;
      ST_COPY:  if (w_copy_last) w_state_next = w_last_pass ? ST_DONE : ST_LOAD;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs and engine memory controls
  always_comb begin
    done_port   = 1'b0;
    w_eng_raddr = 4'd0;
    w_eng_we    = 1'b0;
    w_eng_waddr = 4'd0;
    w_eng_wdata = '0;
    case (r_state)
      ST_LOAD: w_eng_raddr = {1'b0, w_load_idx};
      ST_MERGE: begin
        w_eng_raddr = {1'b0, w_refill_idx};
        w_eng_we    = 1'b1;
        w_eng_waddr = {1'b1, w_out_idx};
        w_eng_wdata = w_take_left ? r_left : r_right;
      end
      ST_COPY: begin
        w_eng_raddr = {1'b1, r_copy};
        w_eng_we    = 1'b1;
        w_eng_waddr = {1'b0, r_copy};
        w_eng_wdata = w_eng_rdata;
      end
      ST_DONE: done_port = 1'b1;
      default: ;
    endcase
  end

  // Merge indices and run heads
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_width     <= 4'd1;
      r_base      <= 3'd0;
      r_i         <= 4'd0;
      r_j         <= 4'd0;
      r_load_step <= 1'b0;
      r_copy      <= 3'd0;
      r_left      <= '0;
      r_right     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_width     <= 4'd1;
          r_base      <= 3'd0;
          r_load_step <= 1'b0;
          r_copy      <= 3'd0;
        end
        ST_LOAD: begin
          r_load_step <= ~r_load_step;
          if (!r_load_step) begin
            r_left <= w_eng_rdata;
          end else begin
            r_right <= w_eng_rdata;
            r_i     <= 4'd0;
            r_j     <= 4'd0;
          end
        end
        ST_MERGE: begin
          if (w_take_left) begin
            r_left <= w_eng_rdata;
            r_i    <= r_i + 4'd1;
          end else begin
            r_right <= w_eng_rdata;
            r_j     <= r_j + 4'd1;
          end
          // Wraps to 0 after the last pair of a pass.
          if (w_pair_last) r_base <= 3'({1'b0, r_base} + w_two_w);
        end
        ST_COPY: begin
          r_copy <= r_copy + 3'd1;
          if (w_copy_last) begin
            r_width <= w_two_w;
            r_base  <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  main_mem #(
    .A_BASE (MEM_var_28859_28863),
    .B_BASE (MEM_var_28861_28867),
    .B_ALIAS(MEM_var_29007_28863)
  ) u_mem (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_slave_en (r_state == ST_IDLE),
    .i_eng_raddr(w_eng_raddr),
    .o_eng_rdata(w_eng_rdata),
    .i_eng_we   (w_eng_we),
    .i_eng_waddr(w_eng_waddr),
    .i_eng_wdata(w_eng_wdata),
    .i_oe       (S_oe_ram),
    .i_we       (S_we_ram),
    .i_addr     (S_addr_ram),
    .i_wdata    (S_Wdata_ram),
    .i_size     (S_data_ram_size),
    .o_rdata    (Sout_Rdata_ram),
    .o_rdy      (Sout_DataRdy)
  );

endmodule

// File: tb/tb_main.sv
// tb_main -- directed scenarios for main with a byte-level memory model, a
// countdown model of the sorter's busy/done timing, and a per-cycle compare.
module tb_main;

  localparam int LATENCY = 62;

  logic        clock;
  logic        reset;
  logic        start_port;
  logic [1:0]  S_oe_ram;
  logic [1:0]  S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  int n_checks = 0;
  int n_errors = 0;

  main dut (
    .clock          (clock),
    .reset          (reset),
    .start_port     (start_port),
    .S_oe_ram       (S_oe_ram),
    .S_we_ram       (S_we_ram),
    .S_addr_ram     (S_addr_ram),
    .S_Wdata_ram    (S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .done_port      (done_port),
    .Sout_Rdata_ram (Sout_Rdata_ram),
    .Sout_DataRdy   (Sout_DataRdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [0:127];
  logic        m_busy;
  int          m_count;
  logic        exp_done;
  logic [1:0]  exp_rdy;
  logic [15:0] exp_rdata;

  function automatic logic [31:0] m_word(input int base, input int i);
    return {m_mem[base+4*i+3], m_mem[base+4*i+2], m_mem[base+4*i+1], m_mem[base+4*i]};
  endfunction

  task automatic m_put(input int base, input int i, input logic [31:0] v);
    for (int b = 0; b < 4; b++) m_mem[base+4*i+b] = v[b*8 +: 8];
  endtask

  task automatic model_reset();
    int init[8] = '{7, -3, 33, 0, 12, -128, 5, 1};
    for (int a = 0; a < 128; a++) m_mem[a] = 8'd0;
    for (int i = 0; i < 8; i++) m_put(64, i, init[i]);
    m_busy = 0; m_count = 0; exp_done = 0; exp_rdy = 0; exp_rdata = 0;
  endtask

  task automatic model_sort();
    int v[8];
    int key;
    int j;
    for (int i = 0; i < 8; i++) v[i] = int'(m_word(64, i));
    for (int i = 1; i < 8; i++) begin
      key = v[i];
      j = i - 1;
      while (j >= 0 && v[j] > key) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = key;
    end
    // The last pass leaves the sorted result in B as well as A.
    for (int i = 0; i < 8; i++) begin
      m_put(64, i, v[i]);
      m_put(32, i, v[i]);
    end
  endtask

  task automatic model_step();
    logic       idle;
    logic [6:0] a [2];
    logic       legal [2];
    idle = !m_busy;
    for (int c = 0; c < 2; c++) begin
      a[c] = S_addr_ram[c*7 +: 7];
      legal[c] = idle && (S_data_ram_size[c*4 +: 4] == 4'd8) && (a[c] >= 7'd32) && (a[c] < 7'd96);
      exp_rdy[c] = S_oe_ram[c] | S_we_ram[c];
      exp_rdata[c*8 +: 8] = (S_oe_ram[c] && legal[c]) ? m_mem[a[c]] : 8'd0;
    end
    for (int c = 0; c < 2; c++) begin
      if (S_we_ram[c] && legal[c]) m_mem[a[c]] = S_Wdata_ram[c*8 +: 8];
    end
    if (m_busy) begin
      m_count++;
      exp_done = (m_count == LATENCY);
      if (m_count > LATENCY) m_busy = 0;
    end else if (start_port) begin
      m_busy = 1;
      m_count = 0;
      model_sort();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("cyc_done",  {31'b0, done_port},    {31'b0, exp_done});
      check("cyc_rdy",   {30'b0, Sout_DataRdy}, {30'b0, exp_rdy});
      check("cyc_rdata", {16'b0, Sout_Rdata_ram}, {16'b0, exp_rdata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic slave_read(input int ch, input int addr, output logic [7:0] d);
    S_oe_ram[ch] = 1'b1;
    S_addr_ram[ch*7 +: 7] = 7'(addr);
    S_data_ram_size[ch*4 +: 4] = 4'd8;
    tick();
    S_oe_ram = 2'b00;
    S_addr_ram = '0;
    S_data_ram_size = '0;
    @(negedge clock);
    check($sformatf("rd_ack@%0d", addr), {31'b0, Sout_DataRdy[ch]}, 32'd1);
    d = Sout_Rdata_ram[ch*8 +: 8];
  endtask

  task automatic slave_write2(input logic [1:0] en, input int a0, input logic [7:0] d0,
                              input int a1, input logic [7:0] d1);
    S_we_ram = en;
    S_addr_ram = {7'(a1), 7'(a0)};
    S_Wdata_ram = {d1, d0};
    S_data_ram_size = 8'h88;
    tick();
    S_we_ram = 2'b00;
    S_addr_ram = '0;
    S_Wdata_ram = '0;
    S_data_ram_size = '0;
    @(negedge clock);
  endtask

  task automatic read_word(input int i, output logic [31:0] w);
    logic [7:0] d;
    for (int b = 0; b < 4; b++) begin
      slave_read(b % 2, 64 + 4*i + b, d);
      w[b*8 +: 8] = d;
    end
  endtask

  task automatic run_sort(input string tag, input bit poke);
    int lat;
    int noisy;
    lat = -1;
    noisy = 0;
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (!poke && (Sout_DataRdy !== 2'b00 || Sout_Rdata_ram !== 16'h0000)) noisy++;
      if (done_port === 1'b1) begin
        lat = k;
        break;
      end
      if (poke && k == 10) begin
        S_we_ram[0] = 1'b1; S_addr_ram[6:0] = 7'd64;
        S_Wdata_ram[7:0] = 8'h99; S_data_ram_size[3:0] = 4'd8;
      end
      if (poke && k == 11) begin
        S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
      end
    end
    check({tag, "_latency"}, lat, LATENCY);
    if (!poke) check({tag, "_quiet"}, noisy, 0);
    tick();
  endtask

  task automatic check_a(input string tag, input logic [31:0] exp[8]);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      read_word(i, w);
      check($sformatf("%s_A%0d", tag, i), w, exp[i]);
      check($sformatf("%s_model_A%0d", tag, i), m_word(64, i), exp[i]);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [31:0] sorted1[8] = '{32'hFFFFFF80, 32'hFFFFFFFD, 32'h0, 32'h1,
                                32'h5, 32'h7, 32'hC, 32'h21};
    logic [31:0] sorted2[8] = '{32'h80000005, 32'hFF000022, 32'hFFFFFFFD, 32'h0,
                                32'h1, 32'h5, 32'h7, 32'hC};
    logic [7:0]  d;
    logic [31:0] w;
    logic [31:0] prev;
    int          pulses;
    bit          ascending;

    reset = 1'b0; start_port = 1'b0;
    S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;

    // Reset held two cycles, outputs must be quiet.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_done",  {31'b0, done_port}, 32'd0);
    check("rst_rdy",   {30'b0, Sout_DataRdy}, 32'd0);
    check("rst_rdata", {16'b0, Sout_Rdata_ram}, 32'd0);

    // First start on the first edge after release; sort the initial table.
    @(posedge clock); #1;
    reset = 1'b1;
    run_sort("run1", 1'b0);
    check_a("run1", sorted1);
    slave_read(1, 32, d);
    check("B0_byte0", {24'b0, d}, 32'h80);

    // Immediate re-start: same latency, A unchanged.
    run_sort("run2", 1'b0);
    check_a("run2", sorted1);

    // Out-of-range reads are acknowledged with zero data.
    slave_read(0, 100, d);
    check("oor_100", {24'b0, d}, 32'h0);
    slave_read(1, 10, d);
    check("oor_10", {24'b0, d}, 32'h0);

    // Byte writes into A[0], a same-byte collision on A[7], then a top byte of A[7].
    slave_write2(2'b01, 64, 8'h05, 0, 8'h00);
    slave_write2(2'b01, 65, 8'h00, 0, 8'h00);
    slave_write2(2'b10, 0, 8'h00, 66, 8'h00);
    slave_write2(2'b01, 67, 8'h80, 0, 8'h00);
    slave_write2(2'b11, 92, 8'h11, 92, 8'h22);
    slave_read(0, 92, d);
    check("ch1_wins", {24'b0, d}, 32'h22);
    slave_write2(2'b10, 0, 8'h00, 95, 8'hFF);
    read_word(0, w);
    check("A0_written", w, 32'h80000005);

    // Sort again with a write attempted mid-run (must be dropped).
    run_sort("run3", 1'b1);
    check_a("run3", sorted2);
    ascending = 1'b1;
    read_word(0, prev);
    for (int i = 1; i < 8; i++) begin
      read_word(i, w);
      if ($signed(w) < $signed(prev)) ascending = 1'b0;
      prev = w;
    end
    check("ascending", {31'b0, ascending}, 32'd1);

    // Reset in the middle of a run: no done pulse, contents restored.
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    pulses = 0;
    repeat (19) @(posedge clock);
    #3 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      if (done_port === 1'b1) pulses++;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (done_port === 1'b1) pulses++;
    end
    check("midrun_no_done", pulses, 0);
    slave_read(0, 64, d);
    check("restored_A0", {24'b0, d}, 32'h07);
    slave_read(1, 32, d);
    check("restored_B0", {24'b0, d}, 32'h00);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
